// File: rtl/spi_frame_arbiter.sv
// Two-requester arbiter that lends one SPI master to a show-ahead FIFO for up to BYTES_PER_FRAME bytes.
// Policy macro SPI_ARB_RR_EN: defined -> round-robin on contention; undefined -> requester 0 always wins.
module spi_frame_arbiter #(
    parameter int BYTES_PER_FRAME = 2
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       empty0,
    input  logic       empty1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic       rdreq0,
    output logic       rdreq1,
    output logic       wrreq0,
    output logic       wrreq1,
    output logic       m_empty,
    output logic [7:0] m_data,
    input  logic       m_rdreq,
    input  logic       m_wrreq,
    input  logic       m_ready,
    output logic [1:0] grant
);
    localparam logic [7:0] FRAME_LEN = 8'(BYTES_PER_FRAME);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [1:0] grant_reg, grant_next;
    logic [7:0] rd_cnt_reg, rd_cnt_next;
    logic [7:0] wr_cnt_reg, wr_cnt_next;

    logic [1:0] rd_strobe;
    logic [1:0] wr_strobe;
    logic       frame_open;
    logic       start;
    logic       pick1;
    logic       owner_empty;
    logic [7:0] owner_data;

    assign frame_open = (rd_cnt_reg < FRAME_LEN);
    assign start      = (state_reg == IDLE) && m_ready && (!empty0 || !empty1);

    // Strobes pass straight through so the show-ahead FIFOs pop in the same cycle the master reads.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign rd_strobe[gi] = m_rdreq & grant_reg[gi] & frame_open;
            assign wr_strobe[gi] = m_wrreq & grant_reg[gi];
        end
    endgenerate

    assign rdreq0 = rd_strobe[0];
    assign rdreq1 = rd_strobe[1];
    assign wrreq0 = wr_strobe[0];
    assign wrreq1 = wr_strobe[1];
    assign grant  = grant_reg;

    assign owner_empty = grant_reg[1] ? empty1 : empty0;
    assign owner_data  = grant_reg[1] ? data1  : data0;

`ifdef SPI_ARB_RR_EN
    logic last_reg, last_next;

    // On contention the requester that did not win last time gets the frame.
    assign pick1     = empty0 | (~empty1 & ~last_reg);
    assign last_next = start ? pick1 : last_reg;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            last_reg <= 1'b1;
        end else begin
            last_reg <= last_next;
        end
    end
`else
    assign pick1 = empty0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg  <= IDLE;
            grant_reg  <= 2'b00;
            rd_cnt_reg <= 8'd0;
            wr_cnt_reg <= 8'd0;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            rd_cnt_reg <= rd_cnt_next;
            wr_cnt_reg <= wr_cnt_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        rd_cnt_next = rd_cnt_reg;
        wr_cnt_next = wr_cnt_reg;
        m_empty     = 1'b1;
        m_data      = 8'h00;

        case (state_reg)
            IDLE: begin
                rd_cnt_next = 8'd0;
                wr_cnt_next = 8'd0;
                if (start) begin
                    grant_next = pick1 ? 2'b10 : 2'b01;
                    state_next = ARM;
                end
            end
            ARM, ACTIVE: begin
                // Fake an empty FIFO once the frame quota is used so the master closes the frame.
                m_empty = owner_empty | ~frame_open;
                m_data  = owner_data;
                if (|rd_strobe) begin
                    rd_cnt_next = rd_cnt_reg + 8'd1;
                end
                if (|wr_strobe) begin
                    wr_cnt_next = wr_cnt_reg + 8'd1;
                end
                if (state_reg == ARM) begin
                    if (!m_ready) begin
                        state_next = ACTIVE;
                    end
                end else if (m_ready && (wr_cnt_reg == rd_cnt_reg)) begin
                    state_next  = IDLE;
                    grant_next  = 2'b00;
                    rd_cnt_next = 8'd0;
                    wr_cnt_next = 8'd0;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = 2'b00;
            end
        endcase
    end
endmodule

// File: tb/tb_spi_frame_arbiter.sv
// Bench for spi_frame_arbiter: a per-cycle vector table for one frame, then FIFO/master model sequences.
module tb_spi_frame_arbiter;
    logic       clk;
    logic       n_rst;
    logic       empty0, empty1;
    logic [7:0] data0, data1;
    logic       rdreq0, rdreq1, wrreq0, wrreq1;
    logic       m_empty;
    logic [7:0] m_data;
    logic       m_rdreq, m_wrreq, m_ready;
    logic [1:0] grant;

    int n_pass  = 0;
    int n_total = 0;

    spi_frame_arbiter #(.BYTES_PER_FRAME(2)) dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .empty0  (empty0),
        .empty1  (empty1),
        .data0   (data0),
        .data1   (data1),
        .rdreq0  (rdreq0),
        .rdreq1  (rdreq1),
        .wrreq0  (wrreq0),
        .wrreq1  (wrreq1),
        .m_empty (m_empty),
        .m_data  (m_data),
        .m_rdreq (m_rdreq),
        .m_wrreq (m_wrreq),
        .m_ready (m_ready),
        .grant   (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        e0, e1;
        logic [7:0]  d0, d1;
        logic        rd, wr, rdy;
        logic [14:0] exp;   // {grant, m_empty, m_data, rdreq0, rdreq1, wrreq0, wrreq1}
    } vec_t;

    vec_t vecs [9];

    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [1:0] fr_g  [$];
    int         fr_rd [$];
    int         fr_wr [$];
    logic       fr_ok [$];
    int         gap_err;
    int         strobe_err;
    logic       timed_out;

    function automatic logic [14:0] outs();
        return {grant, m_empty, m_data, rdreq0, rdreq1, wrreq0, wrreq1};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic set_vec(input int i, input logic e0, input logic e1, input logic [7:0] d0,
                           input logic [7:0] d1, input logic rd, input logic wr, input logic rdy,
                           input logic [14:0] exp);
        vecs[i].e0 = e0; vecs[i].e1 = e1; vecs[i].d0 = d0; vecs[i].d1 = d1;
        vecs[i].rd = rd; vecs[i].wr = wr; vecs[i].rdy = rdy; vecs[i].exp = exp;
    endtask

    task automatic set_pins();
        empty0 = (q0.size() == 0);
        data0  = (q0.size() > 0) ? q0[0] : 8'h00;
        empty1 = (q1.size() == 0);
        data1  = (q1.size() > 0) ? q1[0] : 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_rst = 1'b0;
        m_rdreq = 1'b1; m_wrreq = 1'b1; m_ready = 1'b1;
        empty0 = 1'b0; empty1 = 1'b0; data0 = 8'hFF; data1 = 8'hEE;
        q0.delete(); q1.delete();
        #1;
        check("reset_outputs", 32'(outs()), {17'd0, 2'b00, 1'b1, 8'h00, 4'b0000});
        repeat (2) @(negedge clk);
        m_rdreq = 1'b0; m_wrreq = 1'b0;
        empty0 = 1'b1; empty1 = 1'b1; data0 = 8'h00; data1 = 8'h00;
        n_rst = 1'b1;
    endtask

    // Behavioural SPI master: read a byte, return a MISO byte, repeat while m_empty is low.
    task automatic run_master(input int max_cycles, input logic push_late, input logic [7:0] late_byte);
        logic       busy, pend_wr, pushed, data_ok, done;
        logic [1:0] fg, prev_g;
        logic [7:0] exp_b;
        int         nrd, nwr;
        busy = 0; pend_wr = 0; pushed = 0; data_ok = 1; done = 0;
        fg = 0; prev_g = 0; nrd = 0; nwr = 0;
        fr_g.delete(); fr_rd.delete(); fr_wr.delete(); fr_ok.delete();
        gap_err = 0; strobe_err = 0; timed_out = 0;
        for (int cyc = 0; cyc < max_cycles; cyc++) begin
            @(negedge clk);
            m_rdreq = 1'b0; m_wrreq = 1'b0; m_ready = !busy;
            set_pins();
            #1;
            if (prev_g != 2'b00 && grant != 2'b00 && grant != prev_g) gap_err++;
            if (push_late && !pushed && grant == 2'b01) begin
                q1.push_back(late_byte);
                pushed = 1;
                set_pins();
                #1;
            end
            if (prev_g != 2'b00 && grant == 2'b00) begin
                fr_g.push_back(fg); fr_rd.push_back(nrd); fr_wr.push_back(nwr); fr_ok.push_back(data_ok);
                $display("frame grant=%b reads=%0d writes=%0d data_ok=%b", fg, nrd, nwr, data_ok);
                nrd = 0; nwr = 0; data_ok = 1;
            end
            if (grant != 2'b00) fg = grant;
            prev_g = grant;
            if (!busy && grant == 2'b00 && q0.size() == 0 && q1.size() == 0 && (!push_late || pushed) && cyc > 2) begin
                done = 1;
                break;
            end
            if ((!busy && grant != 2'b00 && !m_empty) || (busy && !pend_wr && !m_empty)) begin
                busy = 1; pend_wr = 1;
                m_rdreq = 1'b1; m_ready = 1'b0;
                if (grant[1]) exp_b = (q1.size() > 0) ? q1[0] : 8'hXX;
                else          exp_b = (q0.size() > 0) ? q0[0] : 8'hXX;
                if (m_data !== exp_b) data_ok = 0;
            end else if (busy && pend_wr) begin
                m_wrreq = 1'b1; pend_wr = 0;
            end else if (busy) begin
                busy = 0; m_ready = 1'b1;
            end
            #1;
            if ((rdreq0 || wrreq0) && grant != 2'b01) strobe_err++;
            if ((rdreq1 || wrreq1) && grant != 2'b10) strobe_err++;
            if (rdreq0 && q0.size() > 0) void'(q0.pop_front());
            if (rdreq1 && q1.size() > 0) void'(q1.pop_front());
            nrd += int'(rdreq0) + int'(rdreq1);
            nwr += int'(wrreq0) + int'(wrreq1);
        end
        if (!done) timed_out = 1;
        m_rdreq = 1'b0; m_wrreq = 1'b0; m_ready = 1'b1;
    endtask

    task automatic check_frame(input string name, input int idx, input logic [1:0] g, input int rd, input int wr);
        logic [31:0] got;
        if (idx < fr_g.size()) got = {13'd0, fr_g[idx], 8'(fr_rd[idx]), 8'(fr_wr[idx]), fr_ok[idx]};
        else                   got = 32'hFFFF_FFFF;
        check(name, got, {13'd0, g, 8'(rd), 8'(wr), 1'b1});
    endtask

    logic [1:0] exp_rr [4];

    initial begin
        n_rst = 1'b0;
        empty0 = 1'b1; empty1 = 1'b1; data0 = 8'h00; data1 = 8'h00;
        m_rdreq = 1'b0; m_wrreq = 1'b0; m_ready = 1'b1;

        // One frame from requester 0 (A5, 3C), cycle by cycle.
        set_vec(0, 1, 1, 8'h00, 8'h00, 1, 1, 1, {2'b00, 1'b1, 8'h00, 4'b0000});
        set_vec(1, 0, 1, 8'hA5, 8'h00, 0, 0, 1, {2'b00, 1'b1, 8'h00, 4'b0000});
        set_vec(2, 0, 1, 8'hA5, 8'h00, 0, 0, 1, {2'b01, 1'b0, 8'hA5, 4'b0000});
        set_vec(3, 0, 1, 8'hA5, 8'h00, 1, 0, 0, {2'b01, 1'b0, 8'hA5, 4'b1000});
        set_vec(4, 0, 1, 8'h3C, 8'h00, 0, 1, 0, {2'b01, 1'b0, 8'h3C, 4'b0010});
        set_vec(5, 0, 1, 8'h3C, 8'h00, 1, 0, 0, {2'b01, 1'b0, 8'h3C, 4'b1000});
        set_vec(6, 1, 1, 8'h00, 8'h00, 1, 1, 0, {2'b01, 1'b1, 8'h00, 4'b0010});
        set_vec(7, 1, 1, 8'h00, 8'h00, 0, 0, 1, {2'b01, 1'b1, 8'h00, 4'b0000});
        set_vec(8, 1, 1, 8'h00, 8'h00, 1, 1, 1, {2'b00, 1'b1, 8'h00, 4'b0000});

        do_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            empty0 = vecs[i].e0; empty1 = vecs[i].e1; data0 = vecs[i].d0; data1 = vecs[i].d1;
            m_rdreq = vecs[i].rd; m_wrreq = vecs[i].wr; m_ready = vecs[i].rdy;
            #1;
            $display("vec %0d grant=%b m_empty=%b m_data=%h rdreq=%b%b wrreq=%b%b",
                     i, grant, m_empty, m_data, rdreq0, rdreq1, wrreq0, wrreq1);
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end

        // Both requesters hold four bytes.
`ifdef SPI_ARB_RR_EN
        exp_rr[0] = 2'b01; exp_rr[1] = 2'b10; exp_rr[2] = 2'b01; exp_rr[3] = 2'b10;
`else
        exp_rr[0] = 2'b01; exp_rr[1] = 2'b01; exp_rr[2] = 2'b10; exp_rr[3] = 2'b10;
`endif
        do_reset();
        q0 = '{8'h11, 8'h22, 8'h33, 8'h44};
        q1 = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        run_master(200, 1'b0, 8'h00);
        check("contest_timeout", 32'(timed_out), 32'd0);
        check("contest_frames", 32'(fr_g.size()), 32'd4);
        for (int i = 0; i < 4; i++) check_frame($sformatf("contest_frame%0d", i), i, exp_rr[i], 2, 2);
        check("contest_gap_strobe", 32'(gap_err + strobe_err), 32'd0);

        // Single-byte frame from requester 1.
        do_reset();
        q1 = '{8'h7E};
        run_master(100, 1'b0, 8'h00);
        check("short_timeout", 32'(timed_out), 32'd0);
        check("short_frames", 32'(fr_g.size()), 32'd1);
        check_frame("short_frame0", 0, 2'b10, 1, 1);

        // Requester 1 arrives while requester 0 owns the master.
        do_reset();
        q0 = '{8'h5A, 8'h5B};
        run_master(100, 1'b1, 8'h99);
        check("late_timeout", 32'(timed_out), 32'd0);
        check("late_frames", 32'(fr_g.size()), 32'd2);
        check_frame("late_frame0", 0, 2'b01, 2, 2);
        check_frame("late_frame1", 1, 2'b10, 1, 1);
        check("late_gap_strobe", 32'(gap_err + strobe_err), 32'd0);

        // Reset asserted after the first byte of a frame.
        do_reset();
        q0 = '{8'hA5, 8'h3C};
        @(negedge clk);
        set_pins(); m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0; m_rdreq = 1'b1;
        #1;
        check("midrst_first_rdreq", {30'd0, rdreq0, rdreq1}, 32'b10);
        @(negedge clk);
        m_rdreq = 1'b0;
        void'(q0.pop_front());
        set_pins();
        #1;
        check("midrst_grant_before", 32'(grant), 32'b01);
        #1 n_rst = 1'b0;
        #1;
        check("midrst_grant_empty", {29'd0, grant, m_empty}, {29'd0, 2'b00, 1'b1});
        m_wrreq = 1'b1;
        #1;
        check("midrst_wrreq_in_reset", {30'd0, wrreq0, wrreq1}, 32'd0);
        @(negedge clk);
        n_rst = 1'b1; m_ready = 1'b1;
        #1;
        check("midrst_after_release", {29'd0, grant, wrreq0 | wrreq1}, 32'd0);
        m_wrreq = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
